// File: rtl/motor_drv_pkg.sv
// Motor drive sequencer shared definitions.
// Holds the sequencer state encoding and the default parameter values used by
// motor_drive_seq and motor_pwm_gen.
package motor_drv_pkg;

  localparam int DUTY_W_DEF   = 8;    // duty / PWM counter width
  localparam int MAX_DUTY_DEF = 200;  // full-run duty
  localparam int RAMP_DIV_DEF = 4;    // cycles per duty step while ramping
  localparam int QUAL_CYC_DEF = 3;    // consecutive grant cycles needed to start

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_RAMP,
    ST_RUN,
    ST_RAMPDN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/motor_pwm_gen.sv
// Free-running PWM generator.
// A DUTY_W-bit counter wraps every 2^DUTY_W cycles; the registered output is
// high while the counter is below the duty value, so duty=k gives k high
// cycles per period and duty=0 gives a constant low.
// Ports:
//   clk    - clock, rising edge
//   resetn - asynchronous active-low reset
//   duty   - duty value
//   pwm    - registered PWM output
module motor_pwm_gen
  import motor_drv_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm
);

  logic [DUTY_W-1:0] cnt_q;
  logic              pwm_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      pwm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_q + DUTY_W'(1);
      pwm_q <= (cnt_q < duty);
    end
  end

  assign pwm = pwm_q;

endmodule

// File: rtl/motor_drive_seq.sv
// Motor drive sequencer: arms on a start pulse, qualifies the drive grant,
// ramps the duty up to MAX_DUTY, holds it, then ramps down to zero and parks.
// Optional macro: MOTOR_DRV_QUAL_EN - when defined, the grant must be high for
// QUAL_CYC consecutive cycles in ARMED before ramping; when undefined any
// single grant-high sample starts the ramp.
// Ports:
//   clk     - clock, rising edge
//   resetn  - asynchronous active-low reset (abandons the sequence at once)
//   f       - one-cycle start pulse
//   g       - drive grant level
//   pwm     - PWM drive output
//   duty    - current duty value
//   running - high in RUN
//   ramping - high in RAMP or RAMPDN
//   done    - high in DONE
//
// state  | meaning
// IDLE   | waiting for start pulse f
// ARMED  | waiting for a qualified grant
// RAMP   | duty stepping up once per RAMP_DIV cycles
// RUN    | duty held at MAX_DUTY until the grant drops
// RAMPDN | duty stepping down once per RAMP_DIV cycles
// DONE   | parked at duty 0 until reset
module motor_drive_seq
  import motor_drv_pkg::*;
#(
  parameter int DUTY_W   = DUTY_W_DEF,
  parameter int MAX_DUTY = MAX_DUTY_DEF,
  parameter int RAMP_DIV = RAMP_DIV_DEF,
  parameter int QUAL_CYC = QUAL_CYC_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              f,
  input  logic              g,
  output logic              pwm,
  output logic [DUTY_W-1:0] duty,
  output logic              running,
  output logic              ramping,
  output logic              done
);

  if (MAX_DUTY < 1 || MAX_DUTY > (2**DUTY_W) - 1 || RAMP_DIV < 1 || QUAL_CYC < 1)
  begin : g_param_check
    $error("motor_drive_seq: parameter out of range");
  end

  localparam int                DIV_W    = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_TC   = DIV_W'(RAMP_DIV - 1);
  localparam logic [DUTY_W-1:0] DUTY_MAX = DUTY_W'(MAX_DUTY);
  localparam logic [DUTY_W-1:0] DUTY_ONE = DUTY_W'(1);

  state_e            state_q, state_d;
  logic [DUTY_W-1:0] duty_q, duty_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              qual_done;

`ifdef MOTOR_DRV_QUAL_EN
  localparam int               QUAL_W  = (QUAL_CYC > 1) ? $clog2(QUAL_CYC) : 1;
  localparam logic [QUAL_W-1:0] QUAL_TC = QUAL_W'(QUAL_CYC - 1);

  logic [QUAL_W-1:0] qual_q, qual_d;

  // Counts consecutive grant-high samples in ARMED; any low sample restarts it.
  always_comb begin
    qual_d = '0;
    if (state_q == ST_ARMED && g && qual_q != QUAL_TC) begin
      qual_d = qual_q + QUAL_W'(1);
    end
  end

  assign qual_done = g && (qual_q == QUAL_TC);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) qual_q <= '0;
    else         qual_q <= qual_d;
  end
`else
  assign qual_done = g;
`endif

  always_comb begin
    state_d = state_q;
    duty_d  = duty_q;
    div_d   = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (f) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (qual_done) state_d = ST_RAMP;
      end
      ST_RAMP: begin
        // A grant drop wins over a pending step; the divider restarts for the ramp-down.
        if (!g) begin
          state_d = (duty_q == '0) ? ST_DONE : ST_RAMPDN;
        end else if (div_q == DIV_TC) begin
          if (duty_q != DUTY_MAX) duty_d = duty_q + DUTY_ONE;
          if (duty_q >= DUTY_MAX - DUTY_ONE) state_d = ST_RUN;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_RUN: begin
        duty_d = DUTY_MAX;
        if (!g) state_d = ST_RAMPDN;
      end
      ST_RAMPDN: begin
        if (duty_q == '0) begin
          state_d = ST_DONE;
        end else if (div_q == DIV_TC) begin
          duty_d = duty_q - DUTY_ONE;
          if (duty_q == DUTY_ONE) state_d = ST_DONE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_DONE: begin
        duty_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        duty_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      div_q   <= '0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      div_q   <= div_d;
    end
  end

  motor_pwm_gen #(
    .DUTY_W(DUTY_W)
  ) u_pwm (
    .clk   (clk),
    .resetn(resetn),
    .duty  (duty_q),
    .pwm   (pwm)
  );

  assign duty    = duty_q;
  assign running = (state_q == ST_RUN);
  assign ramping = (state_q == ST_RAMP) || (state_q == ST_RAMPDN);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_motor_drive_seq.sv
// Testbench for motor_drive_seq. Stimulus is driven on the falling edge and
// the expected post-edge outputs are queued; a monitor pops one entry just
// after each rising edge and compares it with the DUT outputs.
module tb_motor_drive_seq;

  localparam int DUTY_W   = 8;
  localparam int MAX_DUTY = 200;
  localparam int RAMP_DIV = 4;
  localparam int QUAL_CYC = 3;
  localparam int PERIOD   = 1 << DUTY_W;
`ifdef MOTOR_DRV_QUAL_EN
  localparam int QN = QUAL_CYC;
`else
  localparam int QN = 1;
`endif

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              f = 1'b0;
  logic              g = 1'b0;
  logic              pwm;
  logic [DUTY_W-1:0] duty;
  logic              running, ramping, done;

  motor_drive_seq #(
    .DUTY_W  (DUTY_W),
    .MAX_DUTY(MAX_DUTY),
    .RAMP_DIV(RAMP_DIV),
    .QUAL_CYC(QUAL_CYC)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .f      (f),
    .g      (g),
    .pwm    (pwm),
    .duty   (duty),
    .running(running),
    .ramping(ramping),
    .done   (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              pwm;
    logic              running;
    logic              ramping;
    logic              done;
    logic [DUTY_W-1:0] duty;
  } obs_t;

  obs_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: phases plus elapsed-time arithmetic for the ramps.
  typedef enum {P_IDLE, P_ARMED, P_UP, P_FULL, P_DOWN, P_END} phase_t;
  phase_t m_ph;
  int     m_duty, m_t, m_base, m_run, m_tick;

  task automatic model_reset();
    m_ph = P_IDLE; m_duty = 0; m_t = 0; m_base = 0; m_run = 0; m_tick = 0;
  endtask

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, predict the outputs after the next rising edge.
  task automatic cycle(input bit fi, input bit gi);
    obs_t e;
    bit   p;
    f = fi;
    g = gi;
    p = (m_tick % PERIOD) < m_duty;
    m_tick++;
    case (m_ph)
      P_IDLE:  if (fi) m_ph = P_ARMED;
      P_ARMED: begin
        if (gi) begin
          m_run++;
          if (m_run >= QN) begin m_ph = P_UP; m_t = 0; end
        end else begin
          m_run = 0;
        end
      end
      P_UP: begin
        if (!gi) begin
          if (m_duty == 0) m_ph = P_END;
          else begin m_ph = P_DOWN; m_base = m_duty; m_t = 0; end
        end else begin
          m_t++;
          m_duty = m_t / RAMP_DIV;
          if (m_duty == MAX_DUTY) m_ph = P_FULL;
        end
      end
      P_FULL: if (!gi) begin m_ph = P_DOWN; m_base = MAX_DUTY; m_t = 0; end
      P_DOWN: begin
        m_t++;
        m_duty = m_base - m_t / RAMP_DIV;
        if (m_duty == 0) m_ph = P_END;
      end
      default: m_duty = 0;
    endcase
    e.pwm     = p;
    e.running = (m_ph == P_FULL);
    e.ramping = (m_ph == P_UP) || (m_ph == P_DOWN);
    e.done    = (m_ph == P_END);
    e.duty    = DUTY_W'(m_duty);
    sb.push_back(e);
    @(negedge clk);
  endtask

  // Asserts reset between edges, checks outputs clear immediately, releases on a falling edge.
  task automatic async_reset();
    @(posedge clk);
    #3;
    resetn = 1'b0;
    f = 1'b0;
    g = 1'b0;
    #1;
    check("async_reset_outputs", int'({pwm, running, ramping, done, duty}), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    forever begin
      obs_t a, e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = {pwm, running, ramping, done, duty};
        n_cmp++;
        if (a !== e) begin
          n_err++;
          $display("FAIL scoreboard t=%0t: got pwm=%b run=%b rmp=%b done=%b duty=%0d, expected pwm=%b run=%b rmp=%b done=%b duty=%0d",
                   $time, a.pwm, a.running, a.ramping, a.done, a.duty,
                   e.pwm, e.running, e.ramping, e.done, e.duty);
        end
      end
    end
  end

  initial begin
    int highs;
    int guard;
    model_reset();
    async_reset();

    // Armed with grant held low stays parked.
    cycle(1'b1, 1'b0);
    repeat (1000) cycle(1'b0, 1'b0);
    check("armed_g_low_hold", int'({duty, pwm, done, running, ramping}), 0);

    // Short grant burst.
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
`ifdef MOTOR_DRV_QUAL_EN
    check("qual_short_run_ramping", int'(ramping), 0);
    repeat (QUAL_CYC) cycle(1'b0, 1'b1);
    check("qual_full_run_ramping", int'(ramping), 1);
`else
    check("noqual_drop_at_zero_done", int'(done), 1);
    async_reset();
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    check("noqual_single_g_ramps", int'(ramping), 1);
`endif

    // Full ramp up, run, PWM ratio; f on the first edge after reset release.
    async_reset();
    cycle(1'b1, 1'b0);
    repeat (QN) cycle(1'b0, 1'b1);
    check("ramp_entered", int'(ramping), 1);
    check("ramp_duty_start", int'(duty), 0);
    repeat (RAMP_DIV) cycle(1'b0, 1'b1);
    check("ramp_first_step", int'(duty), 1);
    repeat (MAX_DUTY * RAMP_DIV - RAMP_DIV - 1) cycle(1'b0, 1'b1);
    check("ramp_one_short_running", int'(running), 0);
    cycle(1'b0, 1'b1);
    check("run_duty", int'(duty), MAX_DUTY);
    check("run_flag", int'(running), 1);
    repeat (4) cycle(1'b0, 1'b1);
    highs = 0;
    for (int i = 0; i < PERIOD; i++) begin
      cycle(1'b0, 1'b1);
      highs += int'(pwm);
    end
    check("pwm_high_per_period", highs, MAX_DUTY);

    // Reset mid-run abandons the sequence; IDLE ignores g.
    async_reset();
    cycle(1'b0, 1'b1);
    check("idle_ignores_g", int'(ramping), 0);

    // Grant drop mid-ramp at duty 50.
    async_reset();
    cycle(1'b1, 1'b1);
    guard = 0;
    while (m_duty < 50 && guard < 2000) begin
      cycle(1'b0, 1'b1);
      guard++;
    end
    check("reach_duty_50", int'(duty), 50);
    cycle(1'b0, 1'b0);
    check("drop_to_rampdn", int'(ramping), 1);
    check("drop_holds_duty", int'(duty), 50);
    repeat (50 * RAMP_DIV - 1) cycle(1'b0, 1'($urandom_range(0, 1)));
    check("rampdn_one_short_done", int'(done), 0);
    cycle(1'b0, 1'b1);
    check("rampdn_done", int'(done), 1);
    check("done_duty", int'(duty), 0);
    repeat (20) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check("done_sticky", int'(done), 1);

    // Grant drop on the very first ramp cycle goes straight to DONE.
    async_reset();
    cycle(1'b1, 1'b0);
    repeat (QN) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    check("drop_at_zero_done", int'(done), 1);

    // Randomized episodes with sticky grant levels.
    for (int ep = 0; ep < 6; ep++) begin
      bit gl;
      int flip;
      async_reset();
      gl = 1'b0;
      flip = $urandom_range(20, 1500);
      for (int c = 0; c < 2500; c++) begin
        if ($urandom_range(0, flip) == 0) gl = ~gl;
        cycle(1'($urandom_range(0, 15) == 0), gl);
      end
    end

    @(posedge clk);
    #2;
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
